// File: rtl/cpu_controller_if.sv
// Control bus between the instruction sequencer and the CPU datapath.
// master = sequencer (drives strobes), slave = datapath (drives opcode/zero).
interface cpu_controller_if;
  logic [2:0] opcode;
  logic       zero;
  logic [2:0] phase;
  logic       sel;
  logic       rd;
  logic       ld_ir;
  logic       inc_pc;
  logic       ld_pc;
  logic       ld_ac;
  logic       wr;
  logic       data_e;
  logic       halt;

  modport master (
    input  opcode, zero,
    output phase, sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt
  );

  modport slave (
    output opcode, zero,
    input  phase, sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt
  );
endinterface

// File: rtl/cpu_controller.sv
// Eight-phase instruction sequencer for the 8-bit accumulator CPU.
// Phase counter plus a sticky halted flag; all strobes are a
// combinational decode of phase/opcode/zero/halted.
module cpu_controller #(
  parameter logic [2:0] OP_HLT = 3'b000,
  parameter logic [2:0] OP_SKZ = 3'b001,
  parameter logic [2:0] OP_ADD = 3'b010,
  parameter logic [2:0] OP_AND = 3'b011,
  parameter logic [2:0] OP_XOR = 3'b100,
  parameter logic [2:0] OP_LDA = 3'b101,
  parameter logic [2:0] OP_STO = 3'b110,
  parameter logic [2:0] OP_JMP = 3'b111
) (
  input  logic             clk,
  input  logic             rst_n,
  cpu_controller_if.master bus
);

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  phase_t state, state_nxt;
  logic   halted, halted_nxt;

  // Opcode class flags; anything unmatched (incl. X) decodes to no-op.
  logic is_hlt, is_skz, is_sto, is_jmp, is_alu;

  // Classify the IR opcode
  always_comb begin
    is_hlt = 1'b0;
    is_skz = 1'b0;
    is_sto = 1'b0;
    is_jmp = 1'b0;
    is_alu = 1'b0;
    case (bus.opcode)
      OP_HLT:                         is_hlt = 1'b1;
      OP_SKZ:                         is_skz = 1'b1;
      OP_ADD, OP_AND, OP_XOR, OP_LDA: is_alu = 1'b1;
      OP_STO:                         is_sto = 1'b1;
      OP_JMP:                         is_jmp = 1'b1;
      default: ;
    endcase
  end

  // Phase and halted registers; reset overrides halt
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= INST_ADDR;
      halted <= 1'b0;
    end else begin
      state  <= state_nxt;
      halted <= halted_nxt;
    end
  end

  // Next phase and strobe decode
  always_comb begin
    state_nxt  = phase_t'(state + 3'd1);
    halted_nxt = halted;
    bus.sel    = 1'b0;
    bus.rd     = 1'b0;
    bus.ld_ir  = 1'b0;
    bus.inc_pc = 1'b0;
    bus.ld_pc  = 1'b0;
    bus.ld_ac  = 1'b0;
    bus.wr     = 1'b0;
    bus.data_e = 1'b0;
    bus.halt   = 1'b0;
    if (halted) begin
      // Frozen until reset: only halt is visible.
      state_nxt = state;
      bus.halt  = 1'b1;
    end else begin
      case (state)
        INST_ADDR:  bus.sel = 1'b1;
        INST_FETCH: begin
          bus.sel = 1'b1;
          bus.rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          bus.sel   = 1'b1;
          bus.rd    = 1'b1;
          bus.ld_ir = 1'b1;
        end
        OP_ADDR: begin
          bus.inc_pc = 1'b1;
          bus.halt   = is_hlt;
          // Halting lands on OP_FETCH, which is also the normal successor.
          halted_nxt = is_hlt;
        end
        OP_FETCH: bus.rd = is_alu;
        ALU_OP: begin
          bus.rd     = is_alu;
          bus.inc_pc = is_skz & (bus.zero == 1'b1);
          bus.ld_pc  = is_jmp;
          bus.data_e = is_sto;
        end
        STORE: begin
          bus.rd     = is_alu;
          bus.ld_ac  = is_alu;
          bus.inc_pc = is_jmp;
          bus.ld_pc  = is_jmp;
          bus.wr     = is_sto;
          bus.data_e = is_sto;
        end
        default: ;
      endcase
    end
  end

  assign bus.phase = state;

endmodule

// File: tb/tb_cpu_controller.sv
// Randomized + directed bench for cpu_controller with a behavioural model
// and a per-cycle compare on the falling edge.
module tb_cpu_controller;
  localparam logic [2:0] HLT = 3'b000, SKZ = 3'b001, ADD = 3'b010, AND_ = 3'b011,
                         XOR_ = 3'b100, LDA = 3'b101, STO = 3'b110, JMP = 3'b111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  cpu_controller_if bus();

  cpu_controller dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit armed = 0;

  // Model state: phase number and halted flag.
  int m_ph = 0;
  bit m_h = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_ph = 0;
      m_h  = 0;
    end else if (m_h) begin
      m_ph = m_ph;
    end else if (m_ph == 4 && bus.opcode == HLT) begin
      m_h  = 1;
      m_ph = 5;
    end else begin
      m_ph = (m_ph + 1) % 8;
    end
  end

  // Expected {sel,rd,ld_ir,inc_pc,ld_pc,ld_ac,wr,data_e,halt}
  function automatic logic [8:0] expect_out(int ph, bit h, logic [2:0] op, logic z);
    bit alu, run;
    alu = (op == ADD) || (op == AND_) || (op == XOR_) || (op == LDA);
    run = !h;
    expect_out[8] = run && ph <= 3;
    expect_out[7] = run && ((ph >= 1 && ph <= 3) || (ph >= 5 && alu));
    expect_out[6] = run && (ph == 2 || ph == 3);
    expect_out[5] = run && (ph == 4 || (ph == 6 && op == SKZ && z) || (ph == 7 && op == JMP));
    expect_out[4] = run && ph >= 6 && op == JMP;
    expect_out[3] = run && ph == 7 && alu;
    expect_out[2] = run && ph == 7 && op == STO;
    expect_out[1] = run && ph >= 6 && op == STO;
    expect_out[0] = h || (ph == 4 && op == HLT);
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Continuous compare against the model
  always @(negedge clk) begin
    if (armed) begin
      chk("phase", int'(bus.phase), m_ph);
      chk("strobes",
          int'({bus.sel, bus.rd, bus.ld_ir, bus.inc_pc, bus.ld_pc, bus.ld_ac,
                bus.wr, bus.data_e, bus.halt}),
          int'(expect_out(m_ph, m_h, bus.opcode, bus.zero)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until the model sits at phase p; ends #1 after a posedge.
  task automatic goto_phase(input int p);
    int n;
    n = 0;
    while (m_ph != p && n < 16) begin
      tick();
      n++;
    end
    if (m_ph != p) begin
      total++;
      bad++;
      $display("FAIL goto_phase: got=%0d expected=%0d", m_ph, p);
    end
  endtask

  initial begin
    int p0;
    bus.opcode = ADD;
    bus.zero   = 1'b0;
    rst_n      = 1'b0;
    tick();
    armed = 1;
    tick();
    @(negedge clk);
    chk("rst_phase", int'(bus.phase), 0);
    chk("rst_sel",   int'(bus.sel), 1);
    chk("rst_rd",    int'(bus.rd), 0);
    chk("rst_halt",  int'(bus.halt), 0);
    tick();
    rst_n = 1'b1;

    // free run with ADD
    goto_phase(7);
    @(negedge clk);
    chk("add_p7_ld_ac", int'(bus.ld_ac), 1);
    chk("add_p7_rd",    int'(bus.rd), 1);
    p0 = int'(bus.phase);
    repeat (8) tick();
    @(negedge clk);
    chk("wrap8", int'(bus.phase), p0);

    // SKZ
    bus.opcode = SKZ; bus.zero = 1'b1;
    goto_phase(6);
    @(negedge clk);
    chk("skz_z1_inc", int'(bus.inc_pc), 1);
    chk("skz_rd",     int'(bus.rd), 0);
    bus.zero = 1'b0;
    #1;
    chk("skz_z0_inc", int'(bus.inc_pc), 0);
    tick();

    // JMP
    bus.opcode = JMP;
    goto_phase(7);
    @(negedge clk);
    chk("jmp_ld_pc",  int'(bus.ld_pc), 1);
    chk("jmp_inc_pc", int'(bus.inc_pc), 1);
    chk("jmp_wr",     int'(bus.wr), 0);
    tick();

    // STO
    bus.opcode = STO;
    goto_phase(7);
    @(negedge clk);
    chk("sto_wr",     int'(bus.wr), 1);
    chk("sto_data_e", int'(bus.data_e), 1);
    chk("sto_ld_ac",  int'(bus.ld_ac), 0);
    chk("sto_rd",     int'(bus.rd), 0);
    tick();

    // HLT
    bus.opcode = HLT;
    goto_phase(4);
    @(negedge clk);
    chk("hlt_p4_halt", int'(bus.halt), 1);
    chk("hlt_p4_inc",  int'(bus.inc_pc), 1);
    tick();
    @(negedge clk);
    chk("hlt_phase", int'(bus.phase), 5);
    chk("hlt_rd",    int'(bus.rd), 0);
    for (int i = 0; i < 24; i++) begin
      tick();
      bus.opcode = 3'($urandom_range(0, 7));
      bus.zero   = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    chk("hlt_frozen", int'(bus.phase), 5);
    chk("hlt_held",   int'(bus.halt), 1);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("unhalt_phase", int'(bus.phase), 0);
    chk("unhalt_halt",  int'(bus.halt), 0);
    chk("unhalt_sel",   int'(bus.sel), 1);

    // reset mid-instruction
    bus.opcode = STO;
    goto_phase(6);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_phase",  int'(bus.phase), 0);
    chk("midrst_wr",     int'(bus.wr), 0);
    chk("midrst_data_e", int'(bus.data_e), 0);
    chk("midrst_sel",    int'(bus.sel), 1);
    goto_phase(3);
    @(negedge clk);
    chk("resume_p3", int'(bus.phase), 3);

    // random traffic: HLT is rare so most stretches run normally
    for (int i = 0; i < 600; i++) begin
      tick();
      if ($urandom_range(0, 15) == 0) bus.opcode = 3'($urandom_range(0, 7));
      else bus.opcode = 3'($urandom_range(1, 7));
      bus.zero = 1'($urandom_range(0, 1));
      rst_n = ($urandom_range(0, 39) != 0);
    end
    tick();
    armed = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
